// File: rtl/imem_loader.sv
// imem_loader: write-side partner of the instruction memory.
// Takes a byte stream framed as {len_lo, len_hi, 4*N payload bytes}. It assembles
// little-endian 32-bit words and drives the imem write port. The core is held in
// reset (cpu_hold) until the image has been fully written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
//
// Handshake: a byte is consumed on a rising edge where in_valid & in_ready are both 1.
// in_ready depends only on internal state, never on in_valid, and in_data must be
// stable while in_valid is 1.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [31:0]       waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Largest legal image, in words.
  localparam int unsigned CAP = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W = 1;

  // State that follows the final payload write (or a zero-length header).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len_words;
  logic [ADDR_W:0]   word_idx;
  logic [1:0]        byte_sel;
  logic [23:0]       asm_buf;
  logic [15:0]       n16;
  logic              accept;
  logic              last_we;
  logic              start_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  assign accept   = in_valid & in_ready;
  assign n16      = {in_data, len_lo};
  // The write cycle of the final word; all payload bytes have been consumed.
  assign last_we  = we && (word_idx == len_words);
  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and in_ready decode.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (n16 == 16'd0)              state_d = S_FIN;
          else if ({16'd0, n16} > CAP)   state_d = S_ERROR;
          else                           state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Stop taking bytes once the whole payload is in; wait out the last write.
        in_ready = (word_idx != len_words);
        if (last_we) state_d = S_FIN;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (in_data == sum) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Length capture, word assembly and the imem write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo    <= '0;
      len_words <= '0;
      word_idx  <= '0;
      byte_sel  <= '0;
      asm_buf   <= '0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (start_ok) begin
        word_idx <= '0;
        byte_sel <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end
      if (state_q == S_LEN_LO && accept) len_lo <= in_data;
      // Oversized counts are truncated here but go to ERROR, so the value is never used.
      if (state_q == S_LEN_HI && accept) len_words <= (ADDR_W+1)'(n16);
      if (state_q == S_DATA && accept) begin
        byte_sel <= byte_sel + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= sum + in_data;
`endif
        if (byte_sel == 2'd3) begin
          // Fourth byte: latch the complete word; the next word builds in asm_buf.
          wdata    <= {in_data, asm_buf};
          waddr    <= 32'({word_idx[ADDR_W-1:0], 2'b00});
          we       <= 1'b1;
          word_idx <= word_idx + ONE_W;
        end else begin
          asm_buf[8*byte_sel +: 8] <= in_data;
        end
      end
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy         = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
    done         = (state_q == S_DONE);
    error        = (state_q == S_ERROR);
    cpu_hold     = (state_q != S_DONE);
    words_loaded = word_idx;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte frames, expected imem writes in a queue,
// a negedge monitor that pops and compares on every we pulse.
// Honours IMEM_LOADER_CHECKSUM_EN when the design is built with it.
module tb_imem_loader;

  localparam int ADDR_W = 10;

  logic            clk = 1'b0;
  logic            reset, start, in_valid;
  logic [7:0]      in_data;
  logic            in_ready, we, busy, done, error, cpu_hold;
  logic [31:0]     waddr, wdata;
  logic [ADDR_W:0] words_loaded;
  logic [2:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int gap_max = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
    .done(done), .error(error), .cpu_hold(cpu_hold), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write", waddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if ({waddr, wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h required addr 0x%0h data 0x%0h",
                   waddr, wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks; all are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int tmo = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 100) check("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic expect_image();
    exp_q.push_back({32'h0000_0000, 32'h0050_0113});
    exp_q.push_back({32'h0000_0004, 32'h0090_0193});
  endtask

  task automatic send_image();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00,
                             8'h93, 8'h01, 8'h90, 8'h00};
    for (int i = 0; i < 10; i++) send_byte(img[i]);
  endtask

  // Trailing checksum byte when the design expects one (0x88 matches the image).
  task automatic send_good_chk(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(b);
`else
    b = b;
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || error) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("end_timeout", {31'd0, done | error}, 32'd1);
  endtask

  task automatic check_loaded(input string tag, input int words);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(words));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd1);

    // Back-to-back image.
    expect_image();
    pulse_start();
    check("load1_busy", 32'(busy), 32'd1);
    check("load1_in_ready", 32'(in_ready), 32'd1);
    send_image();
    send_good_chk(8'h88);
    wait_end();
    check_loaded("load1", 2);
    repeat (4) @(negedge clk);
    check("load1_done_held", 32'(done), 32'd1);

    // Start from DONE re-holds the core; same image with random gaps.
    gap_max = 3;
    expect_image();
    pulse_start();
    check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_words", 32'(words_loaded), 32'd0);
    send_image();
    send_good_chk(8'h88);
    wait_end();
    check_loaded("gaps", 2);
    gap_max = 0;

    // N = 1025 exceeds capacity.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h04);
    check("big_error", 32'(error), 32'd1);
    check("big_in_ready", 32'(in_ready), 32'd0);
    check("big_cpu_hold", 32'(cpu_hold), 32'd1);
    check("big_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("big_error_held", 32'(error), 32'd1);
    expect_image();
    pulse_start();
    check("recover_error_clr", 32'(error), 32'd0);
    send_image();
    send_good_chk(8'h88);
    wait_end();
    check_loaded("recover", 2);

    // Reset after two payload bytes.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h01);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_words", 32'(words_loaded), 32'd0);
    expect_image();
    pulse_start();
    send_image();
    send_good_chk(8'h88);
    wait_end();
    check_loaded("after_rst", 2);

    // Zero-length image.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_good_chk(8'h00);
    wait_end();
    check_loaded("zero_len", 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum: words are still written, then the load is rejected.
    expect_image();
    pulse_start();
    send_image();
    send_byte(8'h87);
    wait_end();
    check("badchk_error", 32'(error), 32'd1);
    check("badchk_done", 32'(done), 32'd0);
    check("badchk_cpu_hold", 32'(cpu_hold), 32'd1);
    check("badchk_pending", 32'(exp_q.size()), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
